// File: rtl/nand_tb_pkg.sv
// Shared types and constants for the NAND gate stimulus/check block.
package nand_tb_pkg;

   localparam int ERR_W   = 4;
   localparam int VEC_W   = 2;
   localparam logic [ERR_W-1:0] ERR_MAX = 4'd15;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_APPLY = 2'd1,
      S_CHECK = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   // Gray-ordered {a,b} vectors, entry i at bits [2*i+1:2*i]: 00, 01, 11, 10.
   // Only one gate input toggles between consecutive entries.
   localparam logic [7:0] GRAY_TABLE = {2'b10, 2'b11, 2'b01, 2'b00};

   function automatic logic [1:0] gray_vec(input logic [VEC_W-1:0] idx);
      return GRAY_TABLE[2*idx +: 2];
   endfunction

endpackage

// File: rtl/nand_stim_check_sync2.sv
// Two-flop synchronizer with a parameterised reset value.
module sync2 #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // Two back-to-back flops to resolve metastability on the asynchronous input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/nand_stim_check.sv
// Drives a NAND gate through Gray-ordered input vectors, checks its output
// after each hold period and reports mismatch count and pass/fail.
//
// Handshake: start is a one-cycle request honoured only in IDLE; abort
// cancels in any state and wins over start; done is a single-cycle pulse
// issued after the last vector's check, with pass/err_count valid from then
// until the next accepted start.
module nand_stim_check
   import nand_tb_pkg::*;
#(
   parameter int HALF_PERIOD = 20,
   parameter int NUM_LOOPS   = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             abort,
   input  logic             out1,
   output logic             clk1,
   output logic             clk2,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [ERR_W-1:0] err_count,
   output logic [VEC_W-1:0] vec_idx,
   output logic [1:0]       dbg_state
);

   // APPLY lasts HALF_PERIOD-1 cycles: the timer runs 0..HALF_PERIOD-2.
   localparam logic [7:0] HOLD_LAST = 8'(HALF_PERIOD - 2);
   localparam logic [3:0] LOOP_LAST = 4'(NUM_LOOPS - 1);

   state_e     state;
   logic [7:0] timer;
   logic [3:0] loop_cnt;
   logic       out1_sync;

   sync2 #(.RST_VAL(1'b1)) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (out1),
      .q     (out1_sync)
   );

   assign dbg_state = state;

   // Sequencer: applies vectors, checks the synchronized gate output, counts errors.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         clk1      <= 1'b0;
         clk2      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         pass      <= 1'b0;
         err_count <= '0;
         vec_idx   <= '0;
         loop_cnt  <= '0;
         timer     <= '0;
      end else if (abort) begin
         state <= S_IDLE;
         clk1  <= 1'b0;
         clk2  <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
         pass  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  err_count    <= '0;
                  pass         <= 1'b0;
                  vec_idx      <= '0;
                  loop_cnt     <= '0;
                  timer        <= '0;
                  {clk1, clk2} <= gray_vec(2'd0);
                  busy         <= 1'b1;
                  state        <= S_APPLY;
               end
            end
            S_APPLY: begin
               if (timer == HOLD_LAST) begin
                  state <= S_CHECK;
               end else begin
                  timer <= timer + 8'd1;
               end
            end
            S_CHECK: begin
               if ((out1_sync != ~(clk1 & clk2)) && (err_count != ERR_MAX)) begin
                  err_count <= err_count + 4'd1;
               end
               timer <= '0;
               if (vec_idx == 2'd3) begin
                  loop_cnt <= loop_cnt + 4'd1;
                  if (loop_cnt == LOOP_LAST) begin
                     clk1  <= 1'b0;
                     clk2  <= 1'b0;
                     busy  <= 1'b0;
                     state <= S_DONE;
                  end else begin
                     vec_idx      <= '0;
                     {clk1, clk2} <= gray_vec(2'd0);
                     state        <= S_APPLY;
                  end
               end else begin
                  vec_idx      <= vec_idx + 2'd1;
                  {clk1, clk2} <= gray_vec(vec_idx + 2'd1);
                  state        <= S_APPLY;
               end
            end
            S_DONE: begin
               done  <= 1'b1;
               pass  <= (err_count == '0);
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_nand_stim_check.sv
// Bench for nand_stim_check: gate model, vector and result scoreboards.
module tb_nand_stim_check;
   import nand_tb_pkg::*;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT (default parameters) ----------------
   logic       start = 1'b0, abort = 1'b0, out1 = 1'b1;
   logic       clk1, clk2, busy, done, pass;
   logic [3:0] err_count;
   logic [1:0] vec_idx, dbg_state;
   int         mode = 0;   // 0 = correct NAND, 1 = stuck-at-1, 2 = stuck-at-0

   nand_stim_check dut (
      .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .out1(out1),
      .clk1(clk1), .clk2(clk2), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .vec_idx(vec_idx), .dbg_state(dbg_state)
   );

   // ---------------- DUT for saturation (stuck-at-0 gate) ----------------
   logic       start_s = 1'b0, abort_s = 1'b0;
   logic       out1_s;
   logic       clk1_s, clk2_s, busy_s, done_s, pass_s;
   logic [3:0] err_s;
   logic [1:0] vec_idx_s, dbg_state_s;
   assign out1_s = 1'b0;

   nand_stim_check #(.HALF_PERIOD(4), .NUM_LOOPS(15)) dut_sat (
      .clk(clk), .rst_n(rst_n), .start(start_s), .abort(abort_s), .out1(out1_s),
      .clk1(clk1_s), .clk2(clk2_s), .busy(busy_s), .done(done_s), .pass(pass_s),
      .err_count(err_s), .vec_idx(vec_idx_s), .dbg_state(dbg_state_s)
   );

   // Gate model: NAND of the drives with one cycle of delay, or a stuck output.
   always @(posedge clk) begin
      case (mode)
         0:       out1 <= ~(clk1 & clk2);
         1:       out1 <= 1'b1;
         default: out1 <= 1'b0;
      endcase
   end

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- scoreboards ----------------
   logic [3:0] vec_q[$];   // {vec_idx, clk1, clk2} expected at each CHECK
   logic [4:0] exp_q[$];   // {pass, err_count} expected at each done pulse
   int         done_cnt = 0;

   function automatic logic [1:0] exp_vec(input int i);
      case (i)
         0:       return 2'b00;
         1:       return 2'b01;
         2:       return 2'b11;
         default: return 2'b10;
      endcase
   endfunction

   task automatic push_vectors(input int loops);
      for (int l = 0; l < loops; l++)
         for (int i = 0; i < 4; i++)
            vec_q.push_back({2'(i), exp_vec(i)});
   endtask

   // Vector scoreboard: every CHECK cycle must show the next expected vector.
   always @(negedge clk) begin
      if (rst_n && dbg_state == S_CHECK) begin
         if (vec_q.size() == 0) begin
            check("vec_underflow", 32'd1, 32'd0);
         end else begin
            logic [3:0] e;
            e = vec_q.pop_front();
            check("vec_drive", {30'd0, clk1, clk2}, {30'd0, e[1:0]});
            check("vec_idx", {30'd0, vec_idx}, {30'd0, e[3:2]});
         end
      end
   end

   // Result scoreboard: each done pulse pops one expected {pass, err_count}.
   always @(negedge clk) begin
      if (rst_n && done) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            check("done_unexpected", 32'd1, 32'd0);
         end else begin
            logic [4:0] r;
            r = exp_q.pop_front();
            check("pass", {31'd0, pass}, {31'd0, r[4]});
            check("err_count", {28'd0, err_count}, {28'd0, r[3:0]});
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Waits for done; cycles counts edges since the start-sampling edge.
   task automatic wait_done(input int limit, input int restart_at, output int cycles);
      cycles = 0;
      while (!done && cycles < limit) begin
         start = (cycles == restart_at);
         @(posedge clk); #1;
         cycles++;
      end
      start = 1'b0;
      if (!done) check("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Watchdog so the bench can never hang.
   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      int cyc;
      int d0;

      // Reset state
      idle(3);
      check("rst_clk1", {31'd0, clk1}, 32'd0);
      check("rst_clk2", {31'd0, clk2}, 32'd0);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_pass", {31'd0, pass}, 32'd0);
      check("rst_err", {28'd0, err_count}, 32'd0);
      check("rst_vec_idx", {30'd0, vec_idx}, 32'd0);
      check("rst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
      rst_n = 1'b1;
      idle(2);

      // Correct gate: 8 vectors, done 161 cycles after start, pass
      mode = 0;
      push_vectors(2);
      exp_q.push_back({1'b1, 4'd0});
      d0 = done_cnt;
      pulse_start();
      check("busy_after_start", {31'd0, busy}, 32'd1);
      check("drive_idle_to_v0", {30'd0, clk1, clk2}, 32'd0);
      wait_done(400, -1, cyc);
      check("done_latency", cyc, 32'd161);
      check("busy_in_done_cycle", {31'd0, busy}, 32'd0);
      idle(1);
      check("done_one_cycle", {31'd0, done}, 32'd0);
      check("done_count_good", done_cnt - d0, 32'd1);

      // Stuck-at-1 gate: vector 11 mismatches once per loop
      mode = 1;
      push_vectors(2);
      exp_q.push_back({1'b0, 4'd2});
      pulse_start();
      check("err_cleared_on_start", {28'd0, err_count}, 32'd0);
      wait_done(400, -1, cyc);
      check("done_latency_s1", cyc, 32'd161);
      idle(20);
      check("idle_pass_hold", {31'd0, pass}, 32'd0);
      check("idle_err_hold", {28'd0, err_count}, 32'd2);
      check("idle_drive_low", {30'd0, clk1, clk2}, 32'd0);
      check("idle_busy_low", {31'd0, busy}, 32'd0);

      // Second start while busy is ignored
      mode = 0;
      push_vectors(2);
      exp_q.push_back({1'b1, 4'd0});
      d0 = done_cnt;
      pulse_start();
      wait_done(400, 50, cyc);
      check("done_latency_restart", cyc, 32'd161);
      idle(40);
      check("single_done", done_cnt - d0, 32'd1);

      // Abort during loop 1 at vec_idx 2
      push_vectors(2);
      d0 = done_cnt;
      pulse_start();
      idle(124);
      check("abort_pre_idx", {30'd0, vec_idx}, 32'd2);
      check("abort_pre_busy", {31'd0, busy}, 32'd1);
      abort = 1'b1;
      start = 1'b1;
      idle(1);
      abort = 1'b0;
      start = 1'b0;
      check("abort_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
      check("abort_drive", {30'd0, clk1, clk2}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd0);
      check("abort_pass", {31'd0, pass}, 32'd0);
      idle(200);
      check("abort_no_done", done_cnt - d0, 32'd0);
      check("abort_still_idle", {30'd0, dbg_state}, {30'd0, S_IDLE});
      vec_q.delete();

      // Reset asserted during CHECK, then a clean run
      push_vectors(2);
      d0 = done_cnt;
      pulse_start();
      cyc = 0;
      while (dbg_state != S_CHECK && cyc < 100) begin
         idle(1);
         cyc++;
      end
      check("reached_check", {30'd0, dbg_state}, {30'd0, S_CHECK});
      rst_n = 1'b0;
      #1;
      check("mrst_drive", {30'd0, clk1, clk2}, 32'd0);
      check("mrst_busy", {31'd0, busy}, 32'd0);
      check("mrst_done", {31'd0, done}, 32'd0);
      check("mrst_err", {28'd0, err_count}, 32'd0);
      check("mrst_vec_idx", {30'd0, vec_idx}, 32'd0);
      check("mrst_state", {30'd0, dbg_state}, {30'd0, S_IDLE});
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      vec_q.delete();
      idle(30);
      check("mrst_no_done", done_cnt - d0, 32'd0);
      push_vectors(2);
      exp_q.push_back({1'b1, 4'd0});
      pulse_start();
      wait_done(400, -1, cyc);
      check("done_latency_after_rst", cyc, 32'd161);
      idle(3);
      check("done_count_after_rst", done_cnt - d0, 32'd1);

      // Saturation: stuck-at-0 gate, 15 loops, 45 mismatches clamp at 15
      start_s = 1'b1;
      @(posedge clk); #1;
      start_s = 1'b0;
      cyc = 0;
      while (!done_s && cyc < 400) begin
         idle(1);
         cyc++;
      end
      check("sat_done", {31'd0, done_s}, 32'd1);
      check("sat_latency", cyc, 32'd241);
      check("sat_err", {28'd0, err_s}, 32'd15);
      check("sat_pass", {31'd0, pass_s}, 32'd0);

      idle(5);
      check("vec_q_drained", vec_q.size(), 32'd0);
      check("exp_q_drained", exp_q.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/nand_stim_check.md
NAND_STIM_CHECK -- requirements
Module: nand_stim_check

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 20: clock cycles each input vector is held; legal range 4..255.
REQ-002 SHALL have parameter NUM_LOOPS, default 2: number of full 4-vector sweeps per run; legal range 1..15.
REQ-003 SHALL have port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port start  input  1  synchronous run request, sampled in IDLE only.
REQ-006 SHALL have port abort  input  1  synchronous run cancel, any state.
REQ-007 SHALL have port out1  input  1  NAND gate output under test, asynchronous to clk.
REQ-008 SHALL have port clk1  output  1  registered drive to gate input A.
REQ-009 SHALL have port clk2  output  1  registered drive to gate input B.
REQ-010 SHALL have port busy  output  1  high in APPLY and CHECK states.
REQ-011 SHALL have port done  output  1  one-cycle pulse on run completion.
REQ-012 SHALL have port pass  output  1  high when last completed run had zero mismatches.
REQ-013 SHALL have port err_count  output  4  mismatch count of current/last run, saturating at 15.
REQ-014 SHALL have port vec_idx  output  2  index of vector currently applied.

Function
REQ-015 SHALL implement states IDLE, APPLY, CHECK, DONE.
REQ-016 SHALL apply vectors {clk1,clk2} in Gray order 00, 01, 11, 10 for vec_idx 0..3, so only one gate input changes per step.
REQ-017 SHALL, on start=1 in IDLE, clear err_count and pass, load vec_idx=0 and loop counter=0, drive vector 0 on the next cycle and enter APPLY.
REQ-018 SHALL hold each vector exactly HALF_PERIOD cycles: APPLY for HALF_PERIOD-1 cycles, then CHECK for 1 cycle.
REQ-019 SHALL pass out1 through a two-flop synchronizer; CHECK compares the synchronized value with expected ~(clk1 & clk2).
REQ-020 SHALL increment err_count on mismatch in CHECK, saturating at 15 (no wrap).
REQ-021 SHALL, after CHECK of vec_idx 3, increment the loop counter and wrap vec_idx to 0; when the loop counter reaches NUM_LOOPS, enter DONE instead.
REQ-022 SHALL, in DONE (one cycle), pulse done=1, set pass=(err_count==0) including any mismatch in the final CHECK, drive clk1=clk2=0, then return to IDLE.
REQ-023 SHALL hold pass and err_count stable in IDLE until the next accepted start.
REQ-024 SHALL ignore start while busy=1 or in DONE.
REQ-025 SHALL, on abort=1 in any state, go to IDLE next cycle with clk1=clk2=0, no done pulse, pass=0; abort takes priority over simultaneous start.
REQ-026 SHALL keep clk1/clk2 at 0 in IDLE.

Reset
REQ-027 SHALL, on rst_n=0, immediately force state=IDLE, clk1=0, clk2=0, busy=0, done=0, pass=0, err_count=0, vec_idx=0, loop counter=0, synchronizer flops=1.
REQ-028 SHALL, when reset is asserted mid-run, discard the run with no done pulse; operation resumes only on a new start after rst_n deasserts.

Structure
REQ-029 SHALL place the state enum, the 4-entry Gray vector table, and the err_count/vec_idx width constants in shared package nand_tb_pkg.
REQ-030 SHALL instantiate one sub-module, sync2 (two-flop synchronizer, asynchronous active-low reset to a parameterised value), for out1.

Verification
REQ-031 SHALL verify correct gate: out1 = ~(clk1&clk2) with 1-cycle delay, default parameters, start pulse -> 8 vectors, done at cycle 161 after start, pass=1, err_count=0.
REQ-032 SHALL verify stuck-at-1 gate: out1 tied 1, NUM_LOOPS=2 -> 2 mismatches (vector 11 twice), pass=0, err_count=2.
REQ-033 SHALL verify saturation: out1 tied 0, NUM_LOOPS=15 -> 45 mismatches, err_count=15, pass=0.
REQ-034 SHALL verify abort: abort asserted during loop 1, vec_idx 2 -> IDLE next cycle, clk1=clk2=0, done never pulses, pass=0.
REQ-035 SHALL verify reset mid-run: rst_n low for 3 cycles during CHECK -> all outputs 0 immediately; a later start yields a full clean run.
REQ-036 SHALL verify start ignored while busy: a second start at cycle 50 of a run -> no restart, err_count unchanged, single done pulse.
